// File: rtl/position_averager.sv
// Moving-average filter over the last DEPTH solved positions, captured on rising edges of done_in.
// Define OUTLIER_REJECT_EN to discard fixes that deviate more than THRESH from the current average.
module position_averager #(
    parameter  int DEPTH      = 8,
    parameter  int THRESH     = 1000,
    parameter  int MAX_REJECT = 4,
    localparam int LOG2D      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               done_in,
    input  logic signed [63:0] c1,
    input  logic signed [63:0] c2,
    input  logic signed [63:0] c3,
    output logic signed [63:0] avg_x,
    output logic signed [63:0] avg_y,
    output logic signed [63:0] avg_z,
    output logic               avg_valid,
    output logic               busy,
    output logic               overrun,
    output logic               reject,
    output logic [LOG2D:0]     fill_count
);

    localparam int             SW       = 64 + LOG2D;
    localparam logic [LOG2D:0] FULL     = (LOG2D + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;
    localparam logic [1:0] ST_EMIT   = 2'd3;

    logic [1:0]           r_state;
    logic                 r_done_q;
    logic                 r_accept;
    logic                 r_avg_valid;
    logic                 r_overrun;
    logic [LOG2D-1:0]     r_wr_ptr;
    logic [LOG2D:0]       r_fill;
    logic signed [63:0]   r_s   [3];
    logic signed [63:0]   r_old [3];
    logic signed [63:0]   r_avg [3];
    logic signed [SW-1:0] r_sum [3];
    logic signed [63:0]   r_buf [3][DEPTH];

    logic w_rise;
    logic w_busy;
    logic w_accept;

    assign w_rise = done_in & ~r_done_q;
    assign w_busy = (r_state != ST_IDLE);

    function automatic logic signed [SW-1:0] ext(input logic signed [63:0] v);
        return {{LOG2D{v[63]}}, v};
    endfunction

`ifdef OUTLIER_REJECT_EN
    localparam int RCW = $clog2(MAX_REJECT + 1);

    logic [RCW-1:0] r_rej_cnt;
    logic           r_reject;
    logic           w_outlier;

    // 66-bit difference so that |min - max| cannot wrap before the magnitude compare.
    always_comb begin
        logic signed [65:0] v_d;
        v_d       = '0;
        w_outlier = 1'b0;
        for (int a = 0; a < 3; a++) begin
            v_d = {{2{r_s[a][63]}}, r_s[a]} - {{2{r_avg[a][63]}}, r_avg[a]};
            if (v_d < 0) v_d = -v_d;
            if ($unsigned(v_d) > 66'(THRESH)) w_outlier = 1'b1;
        end
    end

    assign w_accept = (r_fill != FULL) || (r_rej_cnt == RCW'(MAX_REJECT)) || !w_outlier;
    assign reject   = r_reject;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{THRESH, MAX_REJECT};
    assign w_accept     = 1'b1;
    assign reject       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_done_q    <= 1'b0;
            r_accept    <= 1'b0;
            r_avg_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            for (int a = 0; a < 3; a++) begin
                r_sum[a] <= '0;
                r_avg[a] <= '0;
            end
`ifdef OUTLIER_REJECT_EN
            r_rej_cnt   <= '0;
            r_reject    <= 1'b0;
`endif
        end else begin
            r_done_q    <= done_in;
            r_avg_valid <= 1'b0;
            r_overrun   <= w_rise && w_busy;
`ifdef OUTLIER_REJECT_EN
            r_reject    <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_rise && en) begin
                        r_s[0]  <= c1;
                        r_s[1]  <= c2;
                        r_s[2]  <= c3;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_accept <= w_accept;
                    for (int a = 0; a < 3; a++) r_old[a] <= r_buf[a][r_wr_ptr];
                    r_state  <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (r_accept) begin
                        for (int a = 0; a < 3; a++) begin
                            if (r_fill == FULL) r_sum[a] <= r_sum[a] - ext(r_old[a]) + ext(r_s[a]);
                            else                r_sum[a] <= r_sum[a] + ext(r_s[a]);
                        end
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_fill != FULL) r_fill <= r_fill + 1'b1;
`ifdef OUTLIER_REJECT_EN
                        r_rej_cnt <= '0;
                    end else begin
                        r_reject  <= 1'b1;
                        r_rej_cnt <= r_rej_cnt + 1'b1;
`endif
                    end
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (r_accept && r_fill == FULL) begin
                        for (int a = 0; a < 3; a++) r_avg[a] <= 64'(r_sum[a] >>> LOG2D);
                        r_avg_valid <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the sample buffer has no reset; fill_count=0 makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (r_state == ST_UPDATE && r_accept) begin
            for (int a = 0; a < 3; a++) r_buf[a][r_wr_ptr] <= r_s[a];
        end
    end

    assign avg_x      = r_avg[0];
    assign avg_y      = r_avg[1];
    assign avg_z      = r_avg[2];
    assign avg_valid  = r_avg_valid;
    assign busy       = w_busy;
    assign overrun    = r_overrun;
    assign fill_count = r_fill;

endmodule

// File: tb/tb_position_averager.sv
// Directed-vector bench for position_averager with DEPTH=4, THRESH=100, MAX_REJECT=2.
// Expectations for the outlier scenario follow whether OUTLIER_REJECT_EN is defined.
module tb_position_averager;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               done_in;
    logic signed [63:0] c1, c2, c3;
    logic signed [63:0] avg_x, avg_y, avg_z;
    logic               avg_valid, busy, overrun, reject;
    logic [2:0]         fill_count;

    int n_cmp = 0;
    int n_err = 0;

    position_averager #(.DEPTH(DEPTH), .THRESH(100), .MAX_REJECT(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .done_in    (done_in),
        .c1         (c1),
        .c2         (c2),
        .c3         (c3),
        .avg_x      (avg_x),
        .avg_y      (avg_y),
        .avg_z      (avg_z),
        .avg_valid  (avg_valid),
        .busy       (busy),
        .overrun    (overrun),
        .reject     (reject),
        .fill_count (fill_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".avg_x"}, avg_x, 0);
        check({tag, ".avg_y"}, avg_y, 0);
        check({tag, ".avg_z"}, avg_z, 0);
        check({tag, ".valid"}, 64'(avg_valid), 0);
        check({tag, ".busy"},  64'(busy), 0);
        check({tag, ".ovr"},   64'(overrun), 0);
        check({tag, ".rej"},   64'(reject), 0);
        check({tag, ".fill"},  64'(fill_count), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One done pulse; samples at N+0.5 (busy), N+2.5 (reject), N+3.5 (average).
    task automatic send_fix(input string tag,
                            input logic signed [63:0] x, y, z,
                            input bit ev,
                            input logic signed [63:0] ex, ey, ez,
                            input bit erej, input int efill);
        @(negedge clk);
        c1 = x; c2 = y; c3 = z; done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        check({tag, ".busy"}, 64'(busy), 1);
        @(negedge clk);
        @(negedge clk);
        check({tag, ".rej"}, 64'(reject), 64'(erej));
        @(negedge clk);
        check({tag, ".valid"}, 64'(avg_valid), 64'(ev));
        check({tag, ".avg_x"}, avg_x, ex);
        check({tag, ".avg_y"}, avg_y, ey);
        check({tag, ".avg_z"}, avg_z, ez);
        check({tag, ".fill"},  64'(fill_count), 64'(efill));
        check({tag, ".idle"},  64'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; done_in = 1'b0;
        c1 = '0; c2 = '0; c3 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle_zero("reset");

        // Window fill and first average
        send_fix("a1", 10, 20, 30, 0, 0, 0, 0, 0, 1);
        send_fix("a2", 14, 24, 34, 0, 0, 0, 0, 0, 2);
        send_fix("a3", 18, 28, 38, 0, 0, 0, 0, 0, 3);
        send_fix("a4", 22, 32, 42, 1, 16, 26, 36, 0, 4);
        // Eviction of the oldest entry with pointer wrap
        send_fix("a5", 26, 36, 46, 1, 20, 30, 40, 0, 4);

        // A rise with en=0 is ignored
        @(negedge clk);
        en = 1'b0; c1 = 999; done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        check("en0.busy", 64'(busy), 0);
        repeat (4) @(negedge clk);
        check("en0.fill", 64'(fill_count), 4);
        check("en0.valid", 64'(avg_valid), 0);
        check("en0.avg_x", avg_x, 20);
        en = 1'b1;

        // Reset while the FSM is in UPDATE
        @(negedge clk);
        c1 = 100; c2 = 100; c3 = 100; done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("midrst");
        rst = 1'b0;
        send_fix("b1", 10, 20, 30, 0, 0, 0, 0, 0, 1);
        send_fix("b2", 14, 24, 34, 0, 0, 0, 0, 0, 2);
        send_fix("b3", 18, 28, 38, 0, 0, 0, 0, 0, 3);
        send_fix("b4", 22, 32, 42, 1, 16, 26, 36, 0, 4);

        // Negative values: floor toward minus infinity
        do_reset();
        send_fix("n1", -3, 0, 0, 0, 0, 0, 0, 0, 1);
        send_fix("n2", -3, 0, 0, 0, 0, 0, 0, 0, 2);
        send_fix("n3", -3, 0, 0, 0, 0, 0, 0, 0, 3);
        send_fix("n4", -3, 0, 0, 1, -3, 0, 0, 0, 4);
        send_fix("n5", -2, 0, 0, 1, -3, 0, 0, 0, 4);

        // Second rise two cycles after the first is dropped
        do_reset();
        @(negedge clk);
        c1 = 7; c2 = 8; c3 = 9; done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        @(negedge clk);
        done_in = 1'b1;
        @(negedge clk);
        done_in = 1'b0;
        check("ovr.pulse", 64'(overrun), 1);
        @(negedge clk);
        check("ovr.clear", 64'(overrun), 0);
        repeat (3) @(negedge clk);
        check("ovr.fill", 64'(fill_count), 1);
        check("ovr.busy", 64'(busy), 0);

        // Full window at zero, then three large fixes
        do_reset();
        send_fix("o1", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        send_fix("o2", 0, 0, 0, 0, 0, 0, 0, 0, 2);
        send_fix("o3", 0, 0, 0, 0, 0, 0, 0, 0, 3);
        send_fix("o4", 0, 0, 0, 1, 0, 0, 0, 0, 4);
`ifdef OUTLIER_REJECT_EN
        send_fix("o5", 500, 0, 0, 0, 0,   0, 0, 1, 4);
        send_fix("o6", 500, 0, 0, 0, 0,   0, 0, 1, 4);
        send_fix("o7", 500, 0, 0, 1, 125, 0, 0, 0, 4);
`else
        send_fix("o5", 500, 0, 0, 1, 125, 0, 0, 0, 4);
        send_fix("o6", 500, 0, 0, 1, 250, 0, 0, 0, 4);
        send_fix("o7", 500, 0, 0, 1, 375, 0, 0, 0, 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
